// File: rtl/aes_pkg.sv
// Shared AES MixColumns types, coefficients and GF(2^8) helpers.
// The coefficient tables cover both directions; the inverse table is only referenced under MIXCOL_INV_EN.
package aes_pkg;

  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned COL_W   = 32;
  localparam int unsigned STATE_W = 128;
  localparam int unsigned CNT_W   = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } fsm_state_e;

  typedef logic [COL_W-1:0]   col_t;
  typedef logic [STATE_W-1:0] aes_state_t;

  localparam logic [BYTE_W-1:0] RED_POLY = 8'h1b;

  // Row 0 coefficients; row r uses the table rotated right by r.
  localparam logic [BYTE_W-1:0] COEF_FWD [4] = '{8'h02, 8'h03, 8'h01, 8'h01};
  localparam logic [BYTE_W-1:0] COEF_INV [4] = '{8'h0e, 8'h0b, 8'h0d, 8'h09};

  function automatic logic [BYTE_W-1:0] xtime(input logic [BYTE_W-1:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? RED_POLY : 8'h00);
  endfunction

  // Shift-and-add multiply; all coefficients fit in 4 bits and fold to constants.
  function automatic logic [BYTE_W-1:0] gf_mul(input logic [BYTE_W-1:0] b,
                                               input logic [BYTE_W-1:0] c);
    logic [BYTE_W-1:0] acc;
    logic [BYTE_W-1:0] p;
    acc = '0;
    p   = b;
    for (int i = 0; i < 4; i++) begin
      if (c[i]) acc = acc ^ p;
      p = xtime(p);
    end
    return acc;
  endfunction

endpackage

// File: rtl/mix_column_unit.sv
// Combinational MixColumns on one 32-bit column (row 0 in the top byte).
// With MIXCOL_INV_EN defined, i_inv selects the InvMixColumns coefficients.
module mix_column_unit
  import aes_pkg::*;
(
`ifdef MIXCOL_INV_EN
  input  logic i_inv,
`endif
  input  col_t i_col,
  output col_t o_col
);

  logic [BYTE_W-1:0] w_a [4];
  logic [BYTE_W-1:0] w_b [4];

  always_comb begin
    for (int r = 0; r < 4; r++) begin
      w_a[r] = i_col[31-8*r -: 8];
    end
    for (int r = 0; r < 4; r++) begin
      w_b[r] = '0;
      for (int k = 0; k < 4; k++) begin
`ifdef MIXCOL_INV_EN
        w_b[r] = w_b[r] ^ gf_mul(w_a[k], i_inv ? COEF_INV[2'(k - r)] : COEF_FWD[2'(k - r)]);
`else
        w_b[r] = w_b[r] ^ gf_mul(w_a[k], COEF_FWD[2'(k - r)]);
`endif
      end
    end
  end

  assign o_col = {w_b[0], w_b[1], w_b[2], w_b[3]};

endmodule

// File: rtl/mix_columns_seq.sv
// Sequential AES MixColumns: one column per cycle through a shared column unit.
// Optional MIXCOL_INV_EN adds the 'inv' port for InvMixColumns.
module mix_columns_seq
  import aes_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
`ifdef MIXCOL_INV_EN
  input  logic               inv,
`endif
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [STATE_W-1:0] in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [STATE_W-1:0] out_data
);

  fsm_state_e           r_state;
  fsm_state_e           w_state_nxt;
  logic [CNT_W-1:0]     r_col_cnt;
  aes_state_t           r_in;
  aes_state_t           r_res;
  logic                 w_load;
  logic                 w_step;
  col_t                 w_col_in;
  col_t                 w_col_out;
`ifdef MIXCOL_INV_EN
  logic                 r_inv;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Clear overrides every accept or handshake decision.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_step      = 1'b0;
    if (clear) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: if (in_valid) begin
          w_load      = 1'b1;
          w_state_nxt = ST_BUSY;
        end
        ST_BUSY: begin
          w_step = 1'b1;
          if (r_col_cnt == 2'd3) w_state_nxt = ST_DONE;
        end
        ST_DONE: if (out_ready) w_state_nxt = ST_IDLE;
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    case (r_col_cnt)
      2'd0:    w_col_in = r_in[127:96];
      2'd1:    w_col_in = r_in[95:64];
      2'd2:    w_col_in = r_in[63:32];
      default: w_col_in = r_in[31:0];
    endcase
  end

  mix_column_unit u_col (
`ifdef MIXCOL_INV_EN
    .i_inv (r_inv),
`endif
    .i_col (w_col_in),
    .o_col (w_col_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_in      <= '0;
      r_res     <= '0;
      r_col_cnt <= '0;
`ifdef MIXCOL_INV_EN
      r_inv     <= 1'b0;
`endif
    end else if (clear) begin
      r_in      <= '0;
      r_res     <= '0;
      r_col_cnt <= '0;
    end else if (w_load) begin
      r_in      <= in_data;
      r_res     <= '0;
      r_col_cnt <= '0;
`ifdef MIXCOL_INV_EN
      r_inv     <= inv;
`endif
    end else if (w_step) begin
      case (r_col_cnt)
        2'd0:    r_res[127:96] <= w_col_out;
        2'd1:    r_res[95:64]  <= w_col_out;
        2'd2:    r_res[63:32]  <= w_col_out;
        default: r_res[31:0]   <= w_col_out;
      endcase
      r_col_cnt <= r_col_cnt + 2'd1;
    end
  end

  assign in_ready  = (r_state == ST_IDLE);
  assign out_valid = (r_state == ST_DONE);
  assign out_data  = r_res;

endmodule

// File: tb/tb_mix_columns_seq.sv
// Directed-vector bench for mix_columns_seq (inverse case under MIXCOL_INV_EN).
module tb_mix_columns_seq;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         clear;
  logic         inv;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;

  int n_vec = 0;
  int n_err = 0;

  localparam logic [127:0] V1 = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
  localparam logic [127:0] E1 = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
  localparam logic [127:0] V2 = 128'hd4d4d4d5_2d26314c_00000000_ffffffff;
  localparam logic [127:0] E2 = 128'hd5d5d7d6_4d7ebdf8_00000000_ffffffff;
  localparam logic [127:0] V3 = 128'h01000000_00010000_80000000_00000001;
  localparam logic [127:0] E3 = 128'h02010103_03020101_1b80809b_01010302;

  always #5 clk = ~clk;

  mix_columns_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
`ifdef MIXCOL_INV_EN
    .inv       (inv),
`endif
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  // Accept one state, count cycles to out_valid; optionally leave it pending in DONE.
  task automatic run_op(input logic [127:0] d, input logic hold,
                        output int lat, output logic [127:0] res);
    int t;
    @(negedge clk);
    in_data  = d;
    in_valid = 1'b1;
    t = 0;
    while (!in_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    while (lat < 20) begin
      @(negedge clk);
      lat++;
      if (out_valid) break;
    end
    res = out_data;
    if (!hold) begin
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    #3;
    n_vec++;
    if (out_valid !== 1'b0 || out_data !== 128'h0) begin
      n_err++;
      $display("FAIL reset_outputs: got valid=%b data=%h want 0/0", out_valid, out_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_vec++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_ready: got in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_forward();
    logic [127:0] vin [3];
    logic [127:0] vexp [3];
    logic [127:0] res;
    int lat;
    vin  = '{V1, V2, V3};
    vexp = '{E1, E2, E3};
    for (int i = 0; i < 3; i++) begin
      run_op(vin[i], 1'b0, lat, res);
      n_vec++;
      if (res !== vexp[i]) begin
        n_err++;
        $display("FAIL forward_%0d: got %h want %h", i, res, vexp[i]);
      end
      n_vec++;
      if (lat !== 5) begin
        n_err++;
        $display("FAIL latency_%0d: got %0d want 5", i, lat);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [127:0] res;
    int lat;
    run_op(V2, 1'b1, lat, res);
    n_vec++;
    if (res !== E2) begin
      n_err++;
      $display("FAIL hold_result: got %h want %h", res, E2);
    end
    in_data  = V1;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_vec++;
      if (out_valid !== 1'b1 || out_data !== E2 || in_ready !== 1'b0) begin
        n_err++;
        $display("FAIL hold_cycle_%0d: got v=%b r=%b d=%h want 1/0/%h",
                 i, out_valid, in_ready, out_data, E2);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    n_vec++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL hold_release: got v=%b r=%b want 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset_midbusy();
    logic [127:0] res;
    int lat;
    @(negedge clk);
    in_data  = V1;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if (out_valid !== 1'b0 || out_data !== 128'h0) begin
      n_err++;
      $display("FAIL async_reset: got v=%b d=%h want 0/0", out_valid, out_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_ready2: got %b want 1", in_ready);
    end
    run_op(V2, 1'b0, lat, res);
    n_vec++;
    if (res !== E2 || lat !== 5) begin
      n_err++;
      $display("FAIL after_reset: got %h lat %0d want %h lat 5", res, lat, E2);
    end
  endtask

  task automatic test_clear();
    logic [127:0] res;
    int lat;
    int seen;
    @(negedge clk);
    in_data  = V1;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    clear = 1'b1;
    @(posedge clk);
    #1 clear = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    n_vec++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL clear_busy: got r=%b v=%b want 1/0", in_ready, out_valid);
    end
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    n_vec++;
    if (seen !== 0) begin
      n_err++;
      $display("FAIL clear_busy_novalid: got %0d valid cycles want 0", seen);
    end
    run_op(V1, 1'b1, lat, res);
    clear     = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1 clear = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    n_vec++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL clear_done: got v=%b r=%b want 0/1", out_valid, in_ready);
    end
    clear    = 1'b1;
    in_valid = 1'b1;
    in_data  = V2;
    @(posedge clk);
    #1 clear = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL clear_idle_accept: got in_ready=%b want 1", in_ready);
    end
  endtask

  task automatic test_back_to_back();
    int acc [2];
    int n_acc;
    int t;
    n_acc = 0;
    acc   = '{0, 0};
    @(negedge clk);
    in_data   = V3;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 14; i++) begin
      if (i > 0) @(negedge clk);
      if (in_valid && in_ready && n_acc < 2) begin
        acc[n_acc] = i;
        n_acc++;
      end
      if (out_valid) begin
        n_vec++;
        if (out_data !== E3) begin
          n_err++;
          $display("FAIL b2b_data_%0d: got %h want %h", i, out_data, E3);
        end
      end
    end
    n_vec++;
    if (n_acc !== 2 || acc[1] - acc[0] !== 6) begin
      n_err++;
      $display("FAIL b2b_spacing: got %0d accepts gap %0d want 2 gap 6",
               n_acc, acc[1] - acc[0]);
    end
    in_valid = 1'b0;
    t = 0;
    while (!in_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    out_ready = 1'b0;
  endtask

`ifdef MIXCOL_INV_EN
  task automatic test_inverse();
    logic [127:0] res;
    int lat;
    inv = 1'b1;
    run_op(E1, 1'b0, lat, res);
    inv = 1'b0;
    n_vec++;
    if (res !== V1) begin
      n_err++;
      $display("FAIL inverse: got %h want %h", res, V1);
    end
  endtask
`endif

  initial begin
    rst_n     = 1'b0;
    clear     = 1'b0;
    inv       = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    test_reset();
    test_forward();
    test_backpressure();
    test_reset_midbusy();
    test_clear();
    test_back_to_back();
`ifdef MIXCOL_INV_EN
    test_inverse();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
